ex2_sad_min_tracker: RTL and testbench
======================================

Name: ex2_sad_min_tracker

Overview:
- EX2-stage consumer of the custom SAD instruction results registered by the EX1/EX2 pipeline register.
- Receives one candidate per cycle (SAD value plus window x/y) and tracks the running minimum across a frame search.
- On frame completion, commits the best x/y to the register file through a shared write-back port with a request/grant handshake.
- Stalls the front of the pipeline while the commit is in progress.

Parameters:
- DATA_W, 32, width of the SAD value and of the coordinates.
- REG_X, 5'd2, destination register for best x ($v0).
- REG_Y, 5'd3, destination register for best y ($v1).
- CNT_W, 16, width of the candidate counter.

Ports:
- Clk  in  1  pipeline clock
- Reset  in  1  synchronous, active-high reset
- frame_start  in  1  pulse: begin new search, clear tracker
- cand_valid_EX2  in  1  a SAD candidate is present in EX2 this cycle
- sad_EX2  in  DATA_W  candidate SAD (unsigned)
- x_EX2  in  DATA_W  candidate window x
- y_EX2  in  DATA_W  candidate window y
- frame_done  in  1  pulse: last candidate issued, commit results
- wb_gnt  in  1  write-back port granted this cycle
- wb_req  out  1  request for the write-back port
- wb_addr  out  5  destination register
- wb_data  out  DATA_W  data to write
- stall_out  out  1  hold IF/ID/EX1 (no new candidates accepted)
- best_sad  out  DATA_W  current minimum SAD
- cand_count  out  CNT_W  candidates accepted this frame (saturating)
- commit_done  out  1  one-cycle pulse after the y write is granted

Behaviour:
- Reset (synchronous, active-high, Clk posedge): state=IDLE, best_sad=all-ones, best_x=best_y=0, cand_count=0, wb_req=0, wb_addr=0, wb_data=0, stall_out=0, commit_done=0.
- Reset mid-commit abandons the commit. No write is issued afterwards.
- States: IDLE, TRACK, COMMIT_X, COMMIT_Y, DONE.
- IDLE: cand_valid ignored. frame_start -> TRACK and clears best_sad/x/y/count.
- TRACK: on cand_valid, compare unsigned sad_EX2 < best_sad.
  - Strictly less: replace best_sad/x/y on the next edge (1-cycle latency).
  - Equal: keep the earlier candidate (first in scan order wins).
  - cand_count increments on every accepted candidate and saturates at all-ones.
- frame_done in TRACK -> COMMIT_X. A cand_valid in the same cycle is folded in before commit; its result is visible in the committed values.
- frame_start in TRACK restarts the search: clear, stay in TRACK. frame_start and frame_done together: frame_done wins, and frame_start is ignored.
- COMMIT_X: wb_req=1, wb_addr=REG_X, wb_data=best_x. Held stable until wb_gnt. On a cycle with wb_gnt -> COMMIT_Y.
- COMMIT_Y: same with REG_Y/best_y. On wb_gnt -> DONE.
- DONE: commit_done=1 for exactly one cycle, wb_req=0 -> IDLE.
- stall_out=1 combinationally in COMMIT_X and COMMIT_Y. cand_valid during those states is a protocol error: ignored, count unchanged.
- frame_done outside TRACK is ignored.
- Zero candidates then frame_done: commits x=0, y=0. best_sad stays all-ones.
- wb_gnt without wb_req: ignored.

Decomposition:
- Shared package: state enum, REG_X/REG_Y defaults, SAD_INIT constant (all-ones).
- Sub-module sad_min_compare (combinational unsigned compare plus select of sad/x/y); everything else stays in the top level.

Test Plan:
- Reset, frame_start, candidates (sad,x,y) = (50,0,0), (20,1,0), (30,2,0), frame_done, wb_gnt tied 1 -> writes r2=1 then r3=0 on consecutive cycles; best_sad=20; cand_count=3; commit_done pulses once.
- Tie: (40,3,4) then (40,5,6), frame_done -> r2=3, r3=4.
- wb_gnt held 0 for 5 cycles in COMMIT_X -> wb_req/addr=2/data stable, stall_out=1 throughout; grant -> proceeds to r3.
- cand_valid (10,7,8) in the same cycle as frame_done after best=20 -> commits r2=7, r3=8.
- Reset asserted in COMMIT_Y -> next cycle wb_req=0, best_sad=FFFFFFFF, state IDLE, no commit_done.
- frame_done with no candidates -> r2=0, r3=0 written; best_sad=FFFFFFFF; cand_count=0.

Source files
------------

// File: rtl/ex2_sad_min_tracker_pkg.sv
// ----------------------------------------------------------------------------
// ex2_sad_min_tracker_pkg
//   Shared definitions for the EX2 SAD minimum tracker:
//   - state_t   : tracker FSM states
//   - REG_X_DEF : default destination register for best x ($v0)
//   - REG_Y_DEF : default destination register for best y ($v1)
//   - SAD_INIT  : "no candidate yet" SAD value (all-ones), sliced to DATA_W
// ----------------------------------------------------------------------------
package ex2_sad_min_tracker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRACK,
        COMMIT_X,
        COMMIT_Y,
        DONE
    } state_t;

    localparam int         DATA_W_DEF = 32;
    localparam int         CNT_W_DEF  = 16;
    localparam logic [4:0] REG_X_DEF  = 5'd2;
    localparam logic [4:0] REG_Y_DEF  = 5'd3;

    // Widest SAD supported; users take the low DATA_W bits.
    localparam int                   SAD_W_MAX = 64;
    localparam logic [SAD_W_MAX-1:0] SAD_INIT  = '1;

endpackage

// File: rtl/ex2_sad_min_tracker_sad_min_compare.sv
// ----------------------------------------------------------------------------
// sad_min_compare
//   Combinational unsigned compare of a candidate SAD against the current
//   minimum, plus select of the winning sad/x/y. Ties keep the current
//   (earlier) entry, so the first candidate in scan order wins.
//
// Ports:
//   cand_sad/x/y : incoming candidate
//   cur_sad/x/y  : current best
//   take         : 1 when the candidate is strictly smaller
//   sel_sad/x/y  : winner of the two
// ----------------------------------------------------------------------------
module sad_min_compare
    import ex2_sad_min_tracker_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] cand_sad,
    input  logic [DATA_W-1:0] cand_x,
    input  logic [DATA_W-1:0] cand_y,
    input  logic [DATA_W-1:0] cur_sad,
    input  logic [DATA_W-1:0] cur_x,
    input  logic [DATA_W-1:0] cur_y,
    output logic              take,
    output logic [DATA_W-1:0] sel_sad,
    output logic [DATA_W-1:0] sel_x,
    output logic [DATA_W-1:0] sel_y
);

    assign take    = (cand_sad < cur_sad);
    assign sel_sad = take ? cand_sad : cur_sad;
    assign sel_x   = take ? cand_x   : cur_x;
    assign sel_y   = take ? cand_y   : cur_y;

endmodule

// File: rtl/ex2_sad_min_tracker.sv
// ----------------------------------------------------------------------------
// ex2_sad_min_tracker
//   EX2-stage consumer of SAD instruction results. Tracks the running minimum
//   SAD (and its window x/y) over a frame search, then commits best x and
//   best y to the register file through a shared write-back port using a
//   request/grant handshake. The front of the pipeline is stalled while the
//   commit is in progress.
//
// Ports:
//   Clk, Reset         : clock, synchronous active-high reset
//   frame_start        : pulse, begin a new search (clears the tracker)
//   cand_valid_EX2     : candidate present this cycle
//   sad_EX2/x_EX2/y_EX2: candidate SAD (unsigned) and window coordinates
//   frame_done         : pulse, last candidate issued -> commit
//   wb_gnt             : write-back port granted this cycle
//   wb_req/addr/data   : write-back request, destination register, data
//   stall_out          : hold IF/ID/EX1 while committing
//   best_sad           : current minimum SAD
//   cand_count         : candidates accepted this frame (saturating)
//   commit_done        : one-cycle pulse after the y write is granted
// ----------------------------------------------------------------------------
module ex2_sad_min_tracker
    import ex2_sad_min_tracker_pkg::*;
#(
    parameter int         DATA_W = DATA_W_DEF,
    parameter logic [4:0] REG_X  = REG_X_DEF,
    parameter logic [4:0] REG_Y  = REG_Y_DEF,
    parameter int         CNT_W  = CNT_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic              cand_valid_EX2,
    input  logic [DATA_W-1:0] sad_EX2,
    input  logic [DATA_W-1:0] x_EX2,
    input  logic [DATA_W-1:0] y_EX2,
    input  logic              frame_done,
    input  logic              wb_gnt,
    output logic              wb_req,
    output logic [4:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              stall_out,
    output logic [DATA_W-1:0] best_sad,
    output logic [CNT_W-1:0]  cand_count,
    output logic              commit_done
);

    localparam logic [DATA_W-1:0] SAD_RESET = SAD_INIT[DATA_W-1:0];

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] best_x;
    logic [DATA_W-1:0] best_y;

    logic              cand_take;
    logic [DATA_W-1:0] sel_sad;
    logic [DATA_W-1:0] sel_x;
    logic [DATA_W-1:0] sel_y;

    logic              accept;
    logic              restart;

    sad_min_compare #(
        .DATA_W (DATA_W)
    ) u_compare (
        .cand_sad (sad_EX2),
        .cand_x   (x_EX2),
        .cand_y   (y_EX2),
        .cur_sad  (best_sad),
        .cur_x    (best_x),
        .cur_y    (best_y),
        .take     (cand_take),
        .sel_sad  (sel_sad),
        .sel_x    (sel_x),
        .sel_y    (sel_y)
    );

    // Candidates only count while tracking; a candidate arriving with
    // frame_done is still folded in before the commit starts.
    assign accept  = (state == TRACK) && cand_valid_EX2;

    // frame_done has priority over frame_start while tracking.
    assign restart = frame_start &&
                     ((state == IDLE) || ((state == TRACK) && !frame_done));

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        wb_req      = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
        stall_out   = 1'b0;
        commit_done = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) state_nxt = TRACK;
            end
            TRACK: begin
                if (frame_done) state_nxt = COMMIT_X;
            end
            COMMIT_X: begin
                wb_req    = 1'b1;
                wb_addr   = REG_X;
                wb_data   = best_x;
                stall_out = 1'b1;
                if (wb_gnt) state_nxt = COMMIT_Y;
            end
            COMMIT_Y: begin
                wb_req    = 1'b1;
                wb_addr   = REG_Y;
                wb_data   = best_y;
                stall_out = 1'b1;
                if (wb_gnt) state_nxt = DONE;
            end
            DONE: begin
                commit_done = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            best_sad   <= SAD_RESET;
            best_x     <= '0;
            best_y     <= '0;
            cand_count <= '0;
        end else begin
            state <= state_nxt;
            if (restart) begin
                best_sad   <= SAD_RESET;
                best_x     <= '0;
                best_y     <= '0;
                cand_count <= '0;
            end else if (accept) begin
                if (cand_take) begin
                    best_sad <= sel_sad;
                    best_x   <= sel_x;
                    best_y   <= sel_y;
                end
                if (cand_count != '1) cand_count <= cand_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ex2_sad_min_tracker.sv
module tb_ex2_sad_min_tracker;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              frame_start;
    logic              cand_valid_EX2;
    logic [DATA_W-1:0] sad_EX2;
    logic [DATA_W-1:0] x_EX2;
    logic [DATA_W-1:0] y_EX2;
    logic              frame_done;
    logic              wb_gnt;
    logic              wb_req;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              stall_out;
    logic [DATA_W-1:0] best_sad;
    logic [CNT_W-1:0]  cand_count;
    logic              commit_done;

    ex2_sad_min_tracker dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_start    (frame_start),
        .cand_valid_EX2 (cand_valid_EX2),
        .sad_EX2        (sad_EX2),
        .x_EX2          (x_EX2),
        .y_EX2          (y_EX2),
        .frame_done     (frame_done),
        .wb_gnt         (wb_gnt),
        .wb_req         (wb_req),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .stall_out      (stall_out),
        .best_sad       (best_sad),
        .cand_count     (cand_count),
        .commit_done    (commit_done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] sad;
        logic [31:0] x;
        logic [31:0] y;
    } cand_t;

    // Scoreboard and reference model state
    wr_t         wb_q[$];
    int          exp_done;
    cand_t       cands[$];
    bit          tracking;
    logic [31:0] m_best_sad;
    int          m_count;

    int n_checks;
    int n_errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: smallest SAD wins, earliest one on a tie; with no
    // candidate the committed coordinates are zero and SAD is all-ones.
    task automatic commit_model();
        cand_t best;
        best = '{32'hFFFF_FFFF, 32'd0, 32'd0};
        foreach (cands[i]) if (cands[i].sad < best.sad) best = cands[i];
        m_best_sad = best.sad;
        m_count    = (cands.size() > 65535) ? 65535 : cands.size();
        wb_q.push_back('{5'd2, best.x});
        wb_q.push_back('{5'd3, best.y});
        exp_done++;
        tracking = 1'b0;
    endtask

    task automatic model_issue(input bit fs, input bit cv, input logic [31:0] s,
                               input logic [31:0] x, input logic [31:0] y, input bit fd);
        if (tracking && fd) begin
            if (cv) cands.push_back('{s, x, y});
            commit_model();
        end else if (fs) begin
            cands.delete();
            tracking = 1'b1;
        end else if (tracking && cv) begin
            cands.push_back('{s, x, y});
        end
    endtask

    // One clock of stimulus; inputs are captured at the next rising edge.
    task automatic step(input bit fs, input bit cv, input logic [31:0] s,
                        input logic [31:0] x, input logic [31:0] y,
                        input bit fd, input bit gnt);
        frame_start    = fs;
        cand_valid_EX2 = cv;
        sad_EX2        = s;
        x_EX2          = x;
        y_EX2          = y;
        frame_done     = fd;
        wb_gnt         = gnt;
        model_issue(fs, cv, s, x, y, fd);
        @(posedge Clk); #1;
        frame_start    = 1'b0;
        cand_valid_EX2 = 1'b0;
        frame_done     = 1'b0;
        wb_gnt         = 1'b0;
    endtask

    // Drive grants until commit_done is seen (bounded); optional stray
    // candidates during the commit must be ignored by the DUT.
    task automatic wait_done(input int gnt_pct, input bit rnd_cv, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < 200) begin
            wb_gnt         = ($urandom_range(0, 99) < gnt_pct);
            cand_valid_EX2 = rnd_cv ? 1'($urandom_range(0, 1)) : 1'b0;
            sad_EX2        = $urandom_range(0, 3);
            x_EX2          = $urandom;
            y_EX2          = $urandom;
            @(negedge Clk);
            cycles++;
            if (commit_done) seen = 1'b1;
            @(posedge Clk); #1;
        end
        cand_valid_EX2 = 1'b0;
        wb_gnt         = 1'b0;
        check("commit_done_seen", 64'(seen), 64'd1);
    endtask

    // Monitor: every granted request must match the next expected write.
    always @(negedge Clk) begin
        if (!Reset) begin
            if (wb_req && wb_gnt) begin
                check("write_expected", 64'(wb_q.size() != 0), 64'd1);
                if (wb_q.size() != 0) begin
                    wr_t w;
                    w = wb_q.pop_front();
                    check("wb_addr", 64'(wb_addr), 64'(w.addr));
                    check("wb_data", 64'(wb_data), 64'(w.data));
                end
            end
            if (wb_req || stall_out)
                check("stall_matches_req", 64'(stall_out), 64'(wb_req));
            if (commit_done) begin
                check("commit_done_expected", 64'(exp_done > 0), 64'd1);
                check("writes_drained_at_done", 64'(wb_q.size()), 64'd0);
                if (exp_done > 0) exp_done--;
            end
        end
    end

    initial begin
        int cyc;
        int n;
        n_checks = 0; n_errors = 0; exp_done = 0; tracking = 1'b0;
        Reset = 1'b1; frame_start = 0; cand_valid_EX2 = 0; sad_EX2 = 0;
        x_EX2 = 0; y_EX2 = 0; frame_done = 0; wb_gnt = 0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Reset state
        check("rst_best_sad", 64'(best_sad), 64'hFFFF_FFFF);
        check("rst_cand_count", 64'(cand_count), 64'd0);
        check("rst_wb_req", 64'(wb_req), 64'd0);
        check("rst_wb_addr", 64'(wb_addr), 64'd0);
        check("rst_wb_data", 64'(wb_data), 64'd0);
        check("rst_stall", 64'(stall_out), 64'd0);
        check("rst_commit_done", 64'(commit_done), 64'd0);

        // IDLE ignores candidates and frame_done
        step(0, 1, 5, 1, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        check("idle_count", 64'(cand_count), 64'd0);
        check("idle_best", 64'(best_sad), 64'hFFFF_FFFF);
        check("idle_no_req", 64'(wb_req), 64'd0);

        // Basic frame, grant tied high
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 50, 0, 0, 0, 0);
        step(0, 1, 20, 1, 0, 0, 0);
        step(0, 1, 30, 2, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        check("basic_best_sad", 64'(best_sad), 64'd20);
        check("basic_count", 64'(cand_count), 64'd3);
        check("basic_stall", 64'(stall_out), 64'd1);
        wait_done(100, 0, cyc);
        check("basic_commit_cycles", 64'(cyc), 64'd3);

        // Tie keeps the earlier candidate
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 40, 3, 4, 0, 0);
        step(0, 1, 40, 5, 6, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        check("tie_best_sad", 64'(best_sad), 64'd40);
        wait_done(100, 0, cyc);

        // Grant withheld for 5 cycles in COMMIT_X
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 7, 11, 12, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("hold_req", 64'(wb_req), 64'd1);
            check("hold_addr", 64'(wb_addr), 64'd2);
            check("hold_data", 64'(wb_data), 64'd11);
            check("hold_stall", 64'(stall_out), 64'd1);
            @(posedge Clk); #1;
        end
        wait_done(100, 0, cyc);

        // Candidate in the frame_done cycle is folded in
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 20, 9, 9, 0, 0);
        step(0, 1, 30, 1, 1, 0, 0);
        step(0, 1, 10, 7, 8, 1, 0);
        check("fold_best_sad", 64'(best_sad), 64'd10);
        check("fold_count", 64'(cand_count), 64'd3);
        wait_done(100, 0, cyc);

        // Restart mid-frame; frame_start + frame_done -> frame_done wins
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 5, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 9, 2, 2, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        check("restart_best_sad", 64'(best_sad), 64'd9);
        check("restart_count", 64'(cand_count), 64'd1);
        wait_done(100, 0, cyc);

        // Zero candidates
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        check("empty_best_sad", 64'(best_sad), 64'hFFFF_FFFF);
        check("empty_count", 64'(cand_count), 64'd0);
        wait_done(100, 0, cyc);

        // Reset during COMMIT_Y abandons the commit
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 3, 4, 5, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        wb_gnt = 1'b1;
        @(posedge Clk); #1;
        wb_gnt = 1'b0;
        Reset  = 1'b1;
        wb_q.delete();
        exp_done = 0;
        tracking = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b0;
        check("midrst_wb_req", 64'(wb_req), 64'd0);
        check("midrst_best_sad", 64'(best_sad), 64'hFFFF_FFFF);
        check("midrst_count", 64'(cand_count), 64'd0);
        check("midrst_commit_done", 64'(commit_done), 64'd0);
        wb_gnt = 1'b1;
        repeat (5) @(posedge Clk);
        #1;
        wb_gnt = 1'b0;
        check("midrst_still_idle", 64'(wb_req), 64'd0);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            step(1, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
            n = $urandom_range(0, 10);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 9) == 0)
                    step(1, 0, 0, 0, 0, 0, 0);
                else
                    step(0, 1'($urandom_range(0, 3) != 0),
                         $urandom_range(0, 1) ? 32'($urandom_range(0, 7)) : $urandom,
                         $urandom, $urandom, 0, 1'($urandom_range(0, 1)));
            end
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 7)), $urandom, $urandom, 1, 0);
            check("rnd_best_sad", 64'(best_sad), 64'(m_best_sad));
            check("rnd_count", 64'(cand_count), 64'(m_count));
            wait_done(50, 1, cyc);
        end

        repeat (3) @(posedge Clk);
        #1;
        check("end_writes_drained", 64'(wb_q.size()), 64'd0);
        check("end_done_drained", 64'(exp_done), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
